// File: rtl/memory_pkg.sv
// Shared memory-subsystem types: L2-TLB <-> PTW request/answer payloads and
// the PTW request arbiter state encoding and owner codes.
package memory_pkg;

  localparam int unsigned VPN_W = 27;
  localparam int unsigned PPN_W = 44;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
  } l2tlb_ptw_req_t;

  typedef struct packed {
    logic             valid;
    logic [PPN_W-1:0] ppn;
    logic             fault;
  } ptw_l2tlb_ans_t;

  typedef enum logic [1:0] {
    PTW_ARB_IDLE  = 2'd0,
    PTW_ARB_ISSUE = 2'd1,
    PTW_ARB_WALK  = 2'd2,
    PTW_ARB_REPLY = 2'd3
  } ptw_arb_state_t;

  localparam logic PTW_ARB_OWNER_I = 1'b0;
  localparam logic PTW_ARB_OWNER_D = 1'b1;

endpackage

// File: rtl/ptw_arb_rr.sv
// Two-way round-robin grant between I and D L2-TLB requests.
// Only compiled when PTW_ARB_RR_EN is defined.
`ifdef PTW_ARB_RR_EN
module ptw_arb_rr (
  input  logic clk,
  input  logic rst_n,
  input  logic itlb_vld,
  input  logic dtlb_vld,
  input  logic accept,
  output logic grant_d
);

  // pointer = side preferred on a tie (0 = I, 1 = D)
  logic ptr;

  always_comb begin
    grant_d = dtlb_vld;
    if (itlb_vld && dtlb_vld) grant_d = ptr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (accept) ptr <= ~grant_d;
  end

endmodule
`endif

// File: rtl/ptw_req_arbiter.sv
// Shares one page-table walker between the I- and D-side L2 TLBs.
// PTW_ARB_RR_EN selects round-robin arbitration; otherwise the D side has fixed priority.
import memory_pkg::*;

module ptw_req_arbiter (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  input  l2tlb_ptw_req_t itlb_req_i,
  output logic           itlb_req_rdy_o,
  output ptw_l2tlb_ans_t itlb_ans_o,
  input  logic           itlb_ans_rdy_i,
  input  l2tlb_ptw_req_t dtlb_req_i,
  output logic           dtlb_req_rdy_o,
  output ptw_l2tlb_ans_t dtlb_ans_o,
  input  logic           dtlb_ans_rdy_i,
  output l2tlb_ptw_req_t ptw_req_o,
  input  logic           ptw_req_rdy_i,
  input  ptw_l2tlb_ans_t ptw_ans_i,
  output logic           ptw_ans_rdy_o
);

  ptw_arb_state_t state;
  l2tlb_ptw_req_t req_buf;
  ptw_l2tlb_ans_t ans_buf;
  logic           owner;
  logic           itlb_ans_vld;
  logic           dtlb_ans_vld;
  logic           grant_d;
  logic           accept;
  logic           owner_rdy;

`ifdef PTW_ARB_RR_EN
  ptw_arb_rr u_rr (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .itlb_vld (itlb_req_i.valid),
    .dtlb_vld (dtlb_req_i.valid),
    .accept   (accept),
    .grant_d  (grant_d)
  );
`else
  assign grant_d = dtlb_req_i.valid;
`endif

  // Flush suppresses the ready so a requester never sees a dropped acceptance.
  always_comb begin
    accept         = (state == PTW_ARB_IDLE) && !flush_i &&
                     (itlb_req_i.valid || dtlb_req_i.valid);
    itlb_req_rdy_o = accept && !grant_d;
    dtlb_req_rdy_o = accept && grant_d;
    owner_rdy      = (owner == PTW_ARB_OWNER_D) ? dtlb_ans_rdy_i : itlb_ans_rdy_i;
  end

  always_comb begin
    ptw_req_o        = req_buf;
    itlb_ans_o       = ans_buf;
    itlb_ans_o.valid = itlb_ans_vld;
    dtlb_ans_o       = ans_buf;
    dtlb_ans_o.valid = dtlb_ans_vld;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= PTW_ARB_IDLE;
      req_buf       <= '0;
      ans_buf       <= '0;
      owner         <= PTW_ARB_OWNER_I;
      itlb_ans_vld  <= 1'b0;
      dtlb_ans_vld  <= 1'b0;
      ptw_ans_rdy_o <= 1'b0;
    end else if (flush_i) begin
      state         <= PTW_ARB_IDLE;
      req_buf.valid <= 1'b0;
      itlb_ans_vld  <= 1'b0;
      dtlb_ans_vld  <= 1'b0;
      ptw_ans_rdy_o <= 1'b0;
    end else begin
      unique case (state)
        PTW_ARB_IDLE: begin
          if (accept) begin
            req_buf <= grant_d ? dtlb_req_i : itlb_req_i;
            owner   <= grant_d;
            state   <= PTW_ARB_ISSUE;
          end
        end
        PTW_ARB_ISSUE: begin
          if (ptw_req_rdy_i) begin
            req_buf.valid <= 1'b0;
            ptw_ans_rdy_o <= 1'b1;
            state         <= PTW_ARB_WALK;
          end
        end
        PTW_ARB_WALK: begin
          if (ptw_ans_i.valid) begin
            ans_buf       <= ptw_ans_i;
            ptw_ans_rdy_o <= 1'b0;
            if (owner == PTW_ARB_OWNER_D) dtlb_ans_vld <= 1'b1;
            else                          itlb_ans_vld <= 1'b1;
            state         <= PTW_ARB_REPLY;
          end
        end
        PTW_ARB_REPLY: begin
          if (owner_rdy) begin
            itlb_ans_vld <= 1'b0;
            dtlb_ans_vld <= 1'b0;
            state        <= PTW_ARB_IDLE;
          end
        end
        default: state <= PTW_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// Directed scoreboard bench for ptw_req_arbiter; expectations follow PTW_ARB_RR_EN.
module tb_ptw_req_arbiter;
  import memory_pkg::*;

`ifdef PTW_ARB_RR_EN
  localparam bit TIE_WINNER = 1'b0;
`else
  localparam bit TIE_WINNER = 1'b1;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  l2tlb_ptw_req_t itlb_req, dtlb_req, ptw_req;
  ptw_l2tlb_ans_t itlb_ans, dtlb_ans, ptw_ans;
  logic           itlb_req_rdy, dtlb_req_rdy, itlb_ans_rdy, dtlb_ans_rdy;
  logic           ptw_req_rdy, ptw_ans_rdy;

  typedef struct {
    bit          side;
    logic [43:0] ppn;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc_n = 0, seen_i = 0, seen_d = 0;

  always #5 clk = ~clk;

  ptw_req_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .itlb_req_i     (itlb_req),
    .itlb_req_rdy_o (itlb_req_rdy),
    .itlb_ans_o     (itlb_ans),
    .itlb_ans_rdy_i (itlb_ans_rdy),
    .dtlb_req_i     (dtlb_req),
    .dtlb_req_rdy_o (dtlb_req_rdy),
    .dtlb_ans_o     (dtlb_ans),
    .dtlb_ans_rdy_i (dtlb_ans_rdy),
    .ptw_req_o      (ptw_req),
    .ptw_req_rdy_i  (ptw_req_rdy),
    .ptw_ans_i      (ptw_ans),
    .ptw_ans_rdy_o  (ptw_ans_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic deliver(input bit side, input logic [43:0] ppn);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk("ans_side", 64'(side), 64'(e.side));
      chk("ans_ppn", 64'(ppn), 64'(e.ppn));
    end
  endtask

  // Monitor just before the rising edge, then move on to the next falling edge.
  task automatic cyc();
    #(4 - ($time % 10));
    if (itlb_ans.valid) seen_i++;
    if (dtlb_ans.valid) seen_d++;
    if (rst_n && !flush) begin
      if (itlb_ans.valid && itlb_ans_rdy) deliver(1'b0, itlb_ans.ppn);
      if (dtlb_ans.valid && dtlb_ans_rdy) deliver(1'b1, dtlb_ans.ppn);
    end
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic set_req(input bit side, input bit vld, input logic [26:0] vpn);
    if (side) begin dtlb_req.valid = vld; dtlb_req.vpn = vpn; end
    else      begin itlb_req.valid = vld; itlb_req.vpn = vpn; end
  endtask

  task automatic accept(input bit side, input logic [26:0] vpn, input logic [43:0] ppn);
    set_req(side, 1'b1, vpn);
    #1;
    chk("req_rdy_winner", 64'(side ? dtlb_req_rdy : itlb_req_rdy), 64'd1);
    chk("req_rdy_other", 64'(side ? itlb_req_rdy : dtlb_req_rdy), 64'd0);
    sb.push_back('{side, ppn});
    cyc();
    set_req(side, 1'b0, 27'd0);
  endtask

  // Runs a granted transaction from ISSUE back to IDLE.
  task automatic finish_txn(input bit side, input logic [26:0] vpn, input logic [43:0] ppn,
                            input int req_wait, input int ans_delay, input int rdy_wait);
    chk("issue_req", 64'({ptw_req.valid, ptw_req.vpn}), 64'({1'b1, vpn}));
    #1;
    chk("issue_rdys", 64'({itlb_req_rdy, dtlb_req_rdy}), 64'd0);
    repeat (req_wait) begin
      cyc();
      chk("stall_req", 64'({ptw_req.valid, ptw_req.vpn}), 64'({1'b1, vpn}));
      #1;
      chk("stall_rdys", 64'({itlb_req_rdy, dtlb_req_rdy}), 64'd0);
    end
    ptw_req_rdy = 1'b1;
    cyc();
    ptw_req_rdy = 1'b0;
    chk("walk_ans_rdy", 64'(ptw_ans_rdy), 64'd1);
    chk("walk_req_vld", 64'(ptw_req.valid), 64'd0);
    repeat (ans_delay) cyc();
    ptw_ans = '0; ptw_ans.valid = 1'b1; ptw_ans.ppn = ppn;
    cyc();
    ptw_ans = '0;
    chk("reply_owner", 64'(side ? {dtlb_ans.valid, dtlb_ans.ppn} : {itlb_ans.valid, itlb_ans.ppn}),
        64'({1'b1, ppn}));
    chk("reply_other", 64'(side ? itlb_ans.valid : dtlb_ans.valid), 64'd0);
    chk("reply_ans_rdy", 64'(ptw_ans_rdy), 64'd0);
    repeat (rdy_wait) begin
      cyc();
      chk("hold_owner", 64'(side ? {dtlb_ans.valid, dtlb_ans.ppn} : {itlb_ans.valid, itlb_ans.ppn}),
          64'({1'b1, ppn}));
      #1;
      chk("hold_rdys", 64'({itlb_req_rdy, dtlb_req_rdy}), 64'd0);
    end
    if (side) dtlb_ans_rdy = 1'b1; else itlb_ans_rdy = 1'b1;
    cyc();
    dtlb_ans_rdy = 1'b0; itlb_ans_rdy = 1'b0;
    chk("idle_ans_vld", 64'({itlb_ans.valid, dtlb_ans.valid}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int si, sd, a0;
    itlb_req = '0; dtlb_req = '0; ptw_ans = '0;
    itlb_ans_rdy = 1'b0; dtlb_ans_rdy = 1'b0; ptw_req_rdy = 1'b0;
    flush = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    cyc(); cyc();
    rst_n = 1'b1;

    // reset state
    chk("rst_valids", 64'({itlb_ans.valid, dtlb_ans.valid, ptw_req.valid, ptw_ans_rdy}), 64'd0);
    #1;
    chk("rst_rdys_noreq", 64'({itlb_req_rdy, dtlb_req_rdy}), 64'd0);

    // single I request, answer 5 cycles into the walk
    si = seen_i; sd = seen_d;
    accept(1'b0, 27'h0ABCDE, 44'h123);
    finish_txn(1'b0, 27'h0ABCDE, 44'h123, 0, 5, 0);
    chk("t1_i_once", 64'(seen_i - si), 64'd1);
    chk("t1_d_none", 64'(seen_d - sd), 64'd0);

    // simultaneous requests, winner stalled 10 cycles by the PTW
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    set_req(1'b0, 1'b1, 27'h0000111);
    set_req(1'b1, 1'b1, 27'h0000222);
    #1;
    chk("tie_grant", 64'({itlb_req_rdy, dtlb_req_rdy}), TIE_WINNER ? 64'd1 : 64'd2);
    sb.push_back('{TIE_WINNER, 44'hAAA});
    cyc();
    set_req(TIE_WINNER, 1'b0, 27'd0);
    finish_txn(TIE_WINNER, TIE_WINNER ? 27'h0000222 : 27'h0000111, 44'hAAA, 10, 1, 0);
    accept(!TIE_WINNER, TIE_WINNER ? 27'h0000111 : 27'h0000222, 44'hBBB);
    finish_txn(!TIE_WINNER, TIE_WINNER ? 27'h0000111 : 27'h0000222, 44'hBBB, 0, 0, 0);

    // D owner holds off the answer for 6 cycles while I keeps requesting
    accept(1'b1, 27'h1234567, 44'hFEDCBA98765);
    set_req(1'b0, 1'b1, 27'h0000333);
    finish_txn(1'b1, 27'h1234567, 44'hFEDCBA98765, 0, 2, 6);
    accept(1'b0, 27'h0000333, 44'h333);
    finish_txn(1'b0, 27'h0000333, 44'h333, 0, 0, 0);

    // flush mid-walk, late PTW answer must be dropped
    accept(1'b0, 27'h0000444, 44'h444);
    ptw_req_rdy = 1'b1; cyc(); ptw_req_rdy = 1'b0;
    chk("fl_walk", 64'(ptw_ans_rdy), 64'd1);
    flush = 1'b1; cyc(); flush = 1'b0;
    sb.delete();
    chk("fl_idle", 64'({ptw_ans_rdy, ptw_req.valid}), 64'd0);
    si = seen_i; sd = seen_d;
    cyc();
    ptw_ans = '0; ptw_ans.valid = 1'b1; ptw_ans.ppn = 44'h444;
    cyc();
    ptw_ans = '0;
    repeat (3) cyc();
    chk("fl_no_ans", 64'({32'(seen_i - si), 32'(seen_d - sd)}), 64'd0);
    chk("fl_ans_rdy", 64'(ptw_ans_rdy), 64'd0);

    // flush in IDLE blocks a concurrent request
    set_req(1'b0, 1'b1, 27'h0000555);
    flush = 1'b1; cyc(); flush = 1'b0;
    set_req(1'b0, 1'b0, 27'd0);
    chk("fl_no_accept", 64'(ptw_req.valid), 64'd0);

    // back-to-back minimum turnaround
    accept(1'b1, 27'h0000666, 44'h666);
    a0 = cyc_n;
    finish_txn(1'b1, 27'h0000666, 44'h666, 0, 0, 0);
    accept(1'b0, 27'h0000777, 44'h777);
    chk("turnaround", 64'(cyc_n - a0), 64'd4);
    finish_txn(1'b0, 27'h0000777, 44'h777, 0, 0, 0);

    // reset during an I reply, then tie goes back to the reset preference
    accept(1'b0, 27'h0000888, 44'h888);
    ptw_req_rdy = 1'b1; cyc(); ptw_req_rdy = 1'b0;
    ptw_ans = '0; ptw_ans.valid = 1'b1; ptw_ans.ppn = 44'h888;
    cyc();
    ptw_ans = '0;
    chk("rr_reply", 64'(itlb_ans.valid), 64'd1);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    sb.delete();
    chk("rr_valids", 64'({itlb_ans.valid, dtlb_ans.valid, ptw_req.valid, ptw_ans_rdy}), 64'd0);
    set_req(1'b0, 1'b1, 27'h0000999);
    set_req(1'b1, 1'b1, 27'h0000AAA);
    #1;
    chk("rr_tie_grant", 64'({itlb_req_rdy, dtlb_req_rdy}), TIE_WINNER ? 64'd1 : 64'd2);
    sb.push_back('{TIE_WINNER, 44'h999});
    cyc();
    set_req(TIE_WINNER, 1'b0, 27'd0);
    finish_txn(TIE_WINNER, TIE_WINNER ? 27'h0000AAA : 27'h0000999, 44'h999, 0, 0, 0);
    accept(!TIE_WINNER, TIE_WINNER ? 27'h0000999 : 27'h0000AAA, 44'hABC);
    finish_txn(!TIE_WINNER, TIE_WINNER ? 27'h0000999 : 27'h0000AAA, 44'hABC, 0, 0, 0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ptw_req_arbiter.md
# ptw_req_arbiter

Shares the single page-table walker (ptw + mmu_cache pair) between two L2-TLB requesters: the instruction-side and the data-side L2 TLB. Accepts one walk request at a time, forwards it to the PTW, records the owner, buffers the PTW answer and returns it only to the owning TLB. Sits between the two L2 TLBs and the ptw_MMU block in the memory subsystem.

## Interface
- No parameters. Request/answer types come from memory_pkg: l2tlb_ptw_req_t and ptw_l2tlb_ans_t, each with a `valid` field.
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- flush_i  in  1  flush; the same signal also drives ptw_MMU.flush_i
- itlb_req_i  in  l2tlb_ptw_req_t  I-side walk request
- itlb_req_rdy_o  out  1  I-side request accepted
- itlb_ans_o  out  ptw_l2tlb_ans_t  I-side answer
- itlb_ans_rdy_i  in  1  I-side ready for answer
- dtlb_req_i, dtlb_req_rdy_o, dtlb_ans_o, dtlb_ans_rdy_i: same as the I-side ports, for the D side
- ptw_req_o  out  l2tlb_ptw_req_t  request to PTW
- ptw_req_rdy_i  in  1  PTW ready
- ptw_ans_i  in  ptw_l2tlb_ans_t  PTW answer
- ptw_ans_rdy_o  out  1  arbiter ready for PTW answer

## Operation
- FSM states: IDLE, ISSUE, WALK, REPLY.
- IDLE
  - The winner is chosen among the valid requests; only the winner sees req_rdy_o=1 (combinational from valid and grant).
  - On accept: the request is captured into req_buf, owner is set to the winner (0=I, 1=D), and the FSM goes to ISSUE.
- ISSUE
  - ptw_req_o = req_buf with valid=1.
  - Stays in ISSUE until ptw_req_rdy_i=1, then goes to WALK.
- WALK
  - ptw_ans_rdy_o=1.
  - On ptw_ans_i.valid: the answer is captured into ans_buf and the FSM goes to REPLY.
- REPLY
  - The owner's ans_o = ans_buf with valid=1. The other side's ans_o.valid=0.
  - Stays in REPLY until the owner's ans_rdy_i=1, then goes to IDLE.
- Both req_rdy_o are 0 outside IDLE. ptw_ans_rdy_o is 0 outside WALK.
- Any ptw_ans_i.valid seen outside WALK is ignored.
- flush_i=1, in any state, takes priority over every transition:
  - next state is IDLE; the buffer valids are cleared; no answer is delivered; a request presented in the same cycle is not accepted.
  - The round-robin pointer is kept.
- Reset
  - FSM goes to IDLE.
  - All `valid` outputs = 0; ptw_ans_rdy_o=0; owner=0; round-robin pointer=0 (I side preferred first).
  - In IDLE after reset, req_rdy_o follows the arbitration rule.
  - A reset asserted mid-walk behaves like flush_i, and also resets the pointer.

## Timing
- Request accepted in cycle N → ptw_req_o.valid in cycle N+1 (registered).
- PTW answer captured in cycle M → owner ans_o.valid in cycle M+1.
- Minimum turnaround, accept to next accept: 4 cycles (PTW ready immediately, answer in the first WALK cycle, owner ready immediately).
- Outputs taken from state/buffers are registered. req_rdy_o is a combinational function of state, requests and pointer.
- Simultaneous flush_i and handshake completion: the flush wins and the transaction is lost; the requester must re-request.

## Configuration
- `PTW_ARB_RR_EN` defined: round-robin arbitration.
  - If both request in IDLE, the side not last granted wins.
  - The pointer updates on each accept.
- `PTW_ARB_RR_EN` undefined: fixed priority, D side always wins; the pointer register is removed.
- A single requester always wins in both modes.

## Structure
- Add to memory_pkg:
  - typedef ptw_arb_state_t (the 4-state enum);
  - constants PTW_ARB_OWNER_I=1'b0 and PTW_ARB_OWNER_D=1'b1.
- One optional sub-module: ptw_arb_rr, the 2-way grant logic plus pointer, compiled under the macro.
- Everything else is flat in ptw_req_arbiter.
- ptw_MMU is instantiated by the parent, not inside this block.

## Test plan
- Single I request, VPN=27'h0ABCDE; PTW ready and answer after 5 cycles, ppn=44'h123 → itlb_ans_o.valid exactly once with ppn 44'h123; dtlb_ans_o.valid stays 0.
- Both sides request in the same cycle after reset, macro defined → I granted first, then D; with the macro undefined → D granted first.
- ptw_req_rdy_i held low for 10 cycles → ptw_req_o stays valid and stable; both req_rdy_o stay 0.
- Owner (D) holds dtlb_ans_rdy_i low for 6 cycles → dtlb_ans_o stays stable; no new request is accepted until the handshake.
- flush_i pulsed in WALK, PTW answer arrives 2 cycles later → no ans_o.valid on either side; the next request is accepted in IDLE with normal 4-cycle turnaround.
- rst_ni low for 1 cycle during REPLY → all valid outputs are 0 the next cycle, then I side wins a simultaneous request (pointer reset).
